// File: rtl/uart_rx_cfg_pkg.sv
// rtl/uart_rx_cfg_pkg.sv - shared types and helpers for the configurable UART receiver
package uart_rx_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// rtl/uart_rx_cfg_if.sv - receive-side handshake bundle between the UART receiver and its consumer
interface uart_rx_cfg_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic                    uart_rx_en;
  logic                    uart_rx_busy;
  logic                    uart_rx_valid;
  logic [PAYLOAD_BITS-1:0] uart_rx_data;
  logic                    uart_rx_parity_err;
  logic                    uart_rx_frame_err;
  logic                    uart_rx_break;

  modport master (
    input  uart_rx_en,
    output uart_rx_busy, uart_rx_valid, uart_rx_data,
    output uart_rx_parity_err, uart_rx_frame_err, uart_rx_break
  );

  modport slave (
    output uart_rx_en,
    input  uart_rx_busy, uart_rx_valid, uart_rx_data,
    input  uart_rx_parity_err, uart_rx_frame_err, uart_rx_break
  );
endinterface

// File: rtl/uart_rx_bit_timer.sv
// rtl/uart_rx_bit_timer.sv - bit-period counter issuing a sample tick at mid-bit
module uart_rx_bit_timer
  import uart_rx_cfg_pkg::*;
#(
  parameter int CYCLES_PER_BIT = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  output logic sample_tick
);
  localparam int HALF_BIT = CYCLES_PER_BIT / 2;
  localparam int CNT_W    = clog2(CYCLES_PER_BIT + 1);

  logic [CNT_W-1:0] count_q;
  logic             first_q;

  assign sample_tick = (count_q == (first_q ? CNT_W'(HALF_BIT) : CNT_W'(CYCLES_PER_BIT)));

  // Reloading 1 on a tick keeps the tick-to-tick spacing at exactly one bit period.
  always_ff @(posedge clk) begin
    if (reset || clear || start) begin
      count_q <= '0;
      first_q <= 1'b1;
    end else if (sample_tick) begin
      count_q <= CNT_W'(1);
      first_q <= 1'b0;
    end else begin
      count_q <= count_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver (width, parity, stop bits, error flags)
// Optional UART_RX_MAJORITY_EN: 3-point majority vote around each mid-bit sample.
module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 48000000,
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          uart_rxd,
  uart_rx_cfg_if.master rx
);
  localparam int   CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam logic PAR_EXPECT     = (PARITY == PAR_ODD);

  if (CYCLES_PER_BIT < 4 || PAYLOAD_BITS < 5 || PAYLOAD_BITS > 9 ||
      PARITY > PAR_EVEN || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
    $error("uart_rx_cfg: illegal parameter combination");
  end

  logic [1:0]              sync_q;
  logic                    rxd_s;
  logic                    sample_tick, sample_en, sample_bit;
  logic                    timer_start, timer_clear, finish;
  rx_state_t               state_q, state_d;
  logic [3:0]              bit_cnt_q;
  logic                    stop_cnt_q;
  logic [PAYLOAD_BITS-1:0] shift_q, data_q;
  logic                    par_bit_q, frame_acc_q, all_zero_q, hold_q;
  logic                    valid_q, par_err_q, frame_err_q, break_q;
  logic                    brk_w, frame_w, par_w, last_data, last_stop;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], uart_rxd};
  end
  assign rxd_s = sync_q[1];

  uart_rx_bit_timer #(.CYCLES_PER_BIT(CYCLES_PER_BIT)) u_timer (
    .clk         (clk),
    .reset       (reset),
    .start       (timer_start),
    .clear       (timer_clear),
    .sample_tick (sample_tick)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;
  logic       tick_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= 2'b11;
      tick_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], rxd_s};
      tick_q <= sample_tick & ~timer_clear;
    end
  end
  assign sample_en  = tick_q;
  assign sample_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxd_s) | (hist_q[0] & rxd_s);
`else
  assign sample_en  = sample_tick;
  assign sample_bit = rxd_s;
`endif

  assign last_data = (bit_cnt_q == 4'(PAYLOAD_BITS - 1));
  assign last_stop = (stop_cnt_q == 1'(STOP_BITS - 1));
  assign brk_w     = all_zero_q & ~sample_bit;
  assign frame_w   = frame_acc_q | ~sample_bit;
  assign par_w     = (PARITY != PAR_NONE) && ((^shift_q ^ par_bit_q) != PAR_EXPECT) && !brk_w;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // hold_q blocks re-arming on a line that is still low after a break.
  always_comb begin
    state_d     = state_q;
    timer_start = 1'b0;
    finish      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx.uart_rx_en && !rxd_s && !hold_q) begin
          state_d     = ST_START;
          timer_start = 1'b1;
        end
      end
      ST_START:  if (sample_en) state_d = sample_bit ? ST_IDLE : ST_DATA;
      ST_DATA:   if (sample_en && last_data) state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (sample_en) state_d = ST_STOP;
      ST_STOP: begin
        if (sample_en && last_stop) begin
          state_d = ST_IDLE;
          finish  = 1'b1;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && !rx.uart_rx_en) begin
      state_d = ST_IDLE;
      finish  = 1'b0;
    end
  end
  assign timer_clear = (state_d == ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      par_bit_q   <= 1'b0;
      frame_acc_q <= 1'b0;
      all_zero_q  <= 1'b1;
      hold_q      <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;
    end else begin
      valid_q <= finish;
      if (state_q == ST_IDLE) begin
        bit_cnt_q   <= '0;
        stop_cnt_q  <= 1'b0;
        frame_acc_q <= 1'b0;
        all_zero_q  <= 1'b1;
      end else if (sample_en) begin
        all_zero_q <= all_zero_q & ~sample_bit;
        case (state_q)
          ST_DATA: begin
            shift_q   <= {sample_bit, shift_q[PAYLOAD_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
          ST_PARITY: par_bit_q <= sample_bit;
          ST_STOP: begin
            stop_cnt_q  <= stop_cnt_q + 1'b1;
            frame_acc_q <= frame_w;
          end
          default: ;
        endcase
      end
      if (finish && brk_w) hold_q <= 1'b1;
      else if (rxd_s)      hold_q <= 1'b0;
      if (finish) begin
        data_q      <= shift_q;
        par_err_q   <= par_w;
        frame_err_q <= frame_w;
        break_q     <= brk_w;
      end
    end
  end

  assign rx.uart_rx_busy       = (state_q != ST_IDLE);
  assign rx.uart_rx_valid      = valid_q;
  assign rx.uart_rx_data       = data_q;
  assign rx.uart_rx_parity_err = par_err_q;
  assign rx.uart_rx_frame_err  = frame_err_q;
  assign rx.uart_rx_break      = break_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - scoreboard bench for uart_rx_cfg (8N1 and 7E2 instances)
module tb_uart_rx_cfg;
  localparam int BIT_RATE   = 9600;
  localparam int CPB        = 128;
  localparam int CLK_HZ     = BIT_RATE * CPB;
  localparam int HALF       = CPB / 2;
  localparam int GLITCH_CYC = 50;
  localparam int EXP_LAT    = 2 + HALF + 8 * CPB + CPB + 1;

  typedef struct packed {
    logic [8:0] data;
    logic       par;
    logic       frm;
    logic       brk;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxd8 = 1'b1;
  logic rxd7 = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   nv8 = 0, nv7 = 0, last_v8 = 0, prev_v8 = 0, t0 = 0, lat = 0;
  logic [7:0] last_data8 = 8'h00;
  logic [6:0] d7;
  logic       p_ok;
  exp_t q8[$];
  exp_t q7[$];

  uart_rx_cfg_if #(.PAYLOAD_BITS(8)) if8 ();
  uart_rx_cfg_if #(.PAYLOAD_BITS(7)) if7 ();

  uart_rx_cfg #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ), .PAYLOAD_BITS(8), .PARITY(0), .STOP_BITS(1))
    dut8 (.clk(clk), .reset(reset), .uart_rxd(rxd8), .rx(if8));
  uart_rx_cfg #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ), .PAYLOAD_BITS(7), .PARITY(2), .STOP_BITS(2))
    dut7 (.clk(clk), .reset(reset), .uart_rxd(rxd7), .rx(if7));

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [8:0] d, input logic p, input logic f, input logic b);
    exp_t e;
    e.data = d; e.par = p; e.frm = f; e.brk = b;
    return e;
  endfunction

  always @(negedge clk) begin : mon8
    exp_t e;
    if (if8.uart_rx_valid === 1'b1) begin
      prev_v8 = last_v8;
      last_v8 = cyc;
      nv8++;
      check("d8_valid_expected", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        check("d8_data",      32'(if8.uart_rx_data),       32'(e.data));
        check("d8_parity",    32'(if8.uart_rx_parity_err), 32'(e.par));
        check("d8_frame_err", 32'(if8.uart_rx_frame_err),  32'(e.frm));
        check("d8_break",     32'(if8.uart_rx_break),      32'(e.brk));
      end
    end
  end

  always @(negedge clk) begin : mon7
    exp_t e;
    if (if7.uart_rx_valid === 1'b1) begin
      nv7++;
      check("d7_valid_expected", 32'(q7.size() != 0), 32'd1);
      if (q7.size() != 0) begin
        e = q7.pop_front();
        check("d7_data",      32'(if7.uart_rx_data),       32'(e.data));
        check("d7_parity",    32'(if7.uart_rx_parity_err), 32'(e.par));
        check("d7_frame_err", 32'(if7.uart_rx_frame_err),  32'(e.frm));
        check("d7_break",     32'(if7.uart_rx_break),      32'(e.brk));
      end
    end
  end

  task automatic send(input bit on7, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (on7) rxd7 = bits[i];
      else     rxd8 = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send8(input logic [7:0] d, input logic stop);
    send(1'b0, {6'b0, stop, d, 1'b0}, 10);
  endtask

  task automatic send7(input logic [6:0] d, input logic p);
    send(1'b1, {5'b0, 2'b11, p, d, 1'b0}, 11);
  endtask

  task automatic check_zero8(input string tag);
    check({tag, "_busy"},  32'(if8.uart_rx_busy),       32'd0);
    check({tag, "_valid"}, 32'(if8.uart_rx_valid),      32'd0);
    check({tag, "_data"},  32'(if8.uart_rx_data),       32'd0);
    check({tag, "_par"},   32'(if8.uart_rx_parity_err), 32'd0);
    check({tag, "_frm"},   32'(if8.uart_rx_frame_err),  32'd0);
    check({tag, "_brk"},   32'(if8.uart_rx_break),      32'd0);
  endtask

  initial begin
    if8.uart_rx_en = 1'b1;
    if7.uart_rx_en = 1'b1;
    repeat (3) @(negedge clk);
    check_zero8("rst8");
    check("rst7_busy",  32'(if7.uart_rx_busy),  32'd0);
    check("rst7_valid", 32'(if7.uart_rx_valid), 32'd0);
    check("rst7_data",  32'(if7.uart_rx_data),  32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 0xA5 with latency measured from the start edge
    q8.push_back(mk(9'h0A5, 1'b0, 1'b0, 1'b0));
    last_data8 = 8'hA5;
    t0 = cyc;
    send8(8'hA5, 1'b1);
    repeat (CPB) @(negedge clk);
    check("t1_valid_count", 32'(nv8), 32'd1);
    lat = last_v8 - t0 - 1;
    check("t1_latency_within_1", 32'(lat >= EXP_LAT - 1 && lat <= EXP_LAT + 1), 32'd1);

    // 7E2 0x35: wrong then correct parity bit
    d7 = 7'h35;
    p_ok = ^d7;
    q7.push_back(mk({2'b00, d7}, 1'b1, 1'b0, 1'b0));
    send7(d7, ~p_ok);
    repeat (CPB) @(negedge clk);
    q7.push_back(mk({2'b00, d7}, 1'b0, 1'b0, 1'b0));
    send7(d7, p_ok);
    repeat (CPB) @(negedge clk);
    check("t2_valid_count", 32'(nv7), 32'd2);

    // stop bit low
    q8.push_back(mk(9'h03C, 1'b0, 1'b1, 1'b0));
    last_data8 = 8'h3C;
    send8(8'h3C, 1'b0);
    rxd8 = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("t3_valid_count", 32'(nv8), 32'd2);

    // break: 12 bit times low, single valid
    q8.push_back(mk(9'h000, 1'b0, 1'b1, 1'b1));
    last_data8 = 8'h00;
    rxd8 = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    rxd8 = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("t4_valid_count", 32'(nv8), 32'd3);

    // short glitch on idle line
    rxd8 = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_glitch_busy", 32'(if8.uart_rx_busy), 32'd1);
    repeat (GLITCH_CYC - 10) @(negedge clk);
    rxd8 = 1'b1;
    repeat (100) @(negedge clk);
    check("t5_glitch_idle", 32'(if8.uart_rx_busy), 32'd0);

    // enable dropped mid-DATA
    send(1'b0, 16'h000C, 4);
    check("t5_abort_busy_before", 32'(if8.uart_rx_busy), 32'd1);
    if8.uart_rx_en = 1'b0;
    rxd8 = 1'b1;
    @(negedge clk);
    check("t5_abort_busy_after", 32'(if8.uart_rx_busy), 32'd0);
    check("t5_abort_data_held", 32'(if8.uart_rx_data), 32'(last_data8));
    repeat (2 * CPB) @(negedge clk);
    if8.uart_rx_en = 1'b1;
    repeat (CPB) @(negedge clk);
    check("t5_valid_count", 32'(nv8), 32'd3);

    // back-to-back frames, then reset mid-frame
    q8.push_back(mk(9'h055, 1'b0, 1'b0, 1'b0));
    q8.push_back(mk(9'h0AA, 1'b0, 1'b0, 1'b0));
    send8(8'h55, 1'b1);
    send8(8'hAA, 1'b1);
    repeat (CPB) @(negedge clk);
    check("t6_valid_count", 32'(nv8), 32'd5);
    check("t6_valid_gap", 32'(last_v8 - prev_v8), 32'(10 * CPB));
    send(1'b0, 16'h0002, 3);
    reset = 1'b1;
    rxd8 = 1'b1;
    @(negedge clk);
    check_zero8("t6_reset");
    reset = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    check("t6_no_valid_after_reset", 32'(nv8), 32'd5);
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q7_drained", 32'(q7.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised successor to the fixed 8N1 UART receiver. Supports configurable payload width, parity mode and stop-bit count, and reports framing, parity and break errors per frame. Sits between the pad-side serial input and the byte-consuming logic (FIFO or register bank) in the UART subsystem.

Parameters:
BIT_RATE, 9600, line rate in bps
CLK_HZ, 48000000, clk frequency in Hz
PAYLOAD_BITS, 8, data bits per frame; legal 5..9
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
STOP_BITS, 1, stop bits per frame; legal 1 or 2

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
uart_rxd  in  1  serial line; asynchronous to clk; idle high
uart_rx_en  in  1  receive enable
uart_rx_busy  out  1  high while a frame is in progress (state != IDLE)
uart_rx_valid  out  1  one-cycle pulse: frame complete, data/flags valid
uart_rx_data  out  PAYLOAD_BITS  received payload, LSB first on the line
uart_rx_parity_err  out  1  qualified by valid; parity mismatch (0 when PARITY=0)
uart_rx_frame_err  out  1  qualified by valid; a stop bit sampled low
uart_rx_break  out  1  qualified by valid; start, data, parity and stop all sampled low

Behaviour:
- Constants: CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer divide); HALF_BIT = CYCLES_PER_BIT/2. Bit counter width is clog2(CYCLES_PER_BIT+1).
- Input path: 2-flop synchroniser on uart_rxd. Both flops reset to 1. FSM sees rxd_s, 2 cycles after the pin.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: counter held at 0. When uart_rx_en=1 and rxd_s=0, go to START.
- START: at count==HALF_BIT, sample rxd_s.
  - If 1: false start; return to IDLE and emit no valid.
  - If 0: reset the counter and go to DATA.
- DATA: sample at each count==CYCLES_PER_BIT, i.e. at the mid-bit point. Shift into the MSB of a right-shift register. After PAYLOAD_BITS samples, go to PARITY if PARITY!=0, otherwise to STOP.
- PARITY: one mid-bit sample. Error when XOR(data, sampled bit) differs from the expected value: 1 for odd, 0 for even.
- STOP: STOP_BITS mid-bit samples. Any low sample sets the frame error.
- After the last stop sample the FSM returns to IDLE the next cycle. It does not wait for the end of the stop bit, so back-to-back frames are accepted.
- uart_rx_valid rises the cycle after the last stop sample and is high for exactly 1 cycle. uart_rx_data and all three flags update in that same cycle and hold until the next valid.
- Break: every sampled bit in the frame was 0. A break also asserts frame_err. parity_err is forced to 0 when break=1.
- uart_rx_en deasserted in any non-IDLE state: abort to IDLE on the next cycle; no valid; data and flags unchanged.
- Reset (also mid-frame): state IDLE, counters 0, shift register 0. Outputs valid=0, busy=0, data=0, all flags=0.
- Any legal parameter combination whose CYCLES_PER_BIT < 4 is a static error (elaboration assertion).

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each sample is the majority of rxd_s at count-1, count and count+1. This adds 1 cycle of latency to sampling only; the valid timing relative to the stop-bit midpoint shifts by +1 cycle.
- Undefined: single-point sample at the midpoint, exactly as described above.

Decomposition:
- Package uart_rx_cfg_pkg: FSM state enum, parity mode constants (PAR_NONE, PAR_ODD, PAR_EVEN), and a clog2 helper function.
- One sub-module, uart_rx_bit_timer. It contains the cycle counter and emits a one-cycle sample_tick at HALF_BIT (first bit) or CYCLES_PER_BIT (subsequent bits). Inputs: start, clear. The FSM stays in the top module.

Test Plan:
1. 8N1, CLK_HZ=48e6 (5000 cycles/bit): send 0xA5 -> one valid pulse, data=0xA5, all flags 0; valid rises 2+2500+8*5000+5000+1 cycles after the start edge (±1).
2. PAYLOAD_BITS=7, PARITY=2, STOP_BITS=2: send 0x35 with wrong parity bit 1 -> data=0x35, parity_err=1, frame_err=0; correct parity bit 0 -> parity_err=0.
3. 8N1: send 0x3C with stop bit driven low -> valid, data=0x3C, frame_err=1, break=0.
4. Hold uart_rxd low for 12 bit times -> single valid, data=0x00, break=1, frame_err=1, parity_err=0; no further valid until the line returns high and a new start occurs.
5. 1000 ns low glitch on idle line -> busy pulses for about HALF_BIT cycles, then returns to 0; no valid. Repeat with uart_rx_en dropped mid-DATA -> busy=0 next cycle, no valid, data keeps its previous value.
6. Back-to-back 0x55, 0xAA with a single stop bit, no idle gap -> two valid pulses one frame apart with correct data; assert reset for 1 cycle mid-frame of a third byte -> all outputs 0, no valid for that byte.
